// File: rtl/clip_record_play_ctrl.sv
// ----------------------------------------------------------------------------
// clip_record_play_ctrl
//
// Multi-clip audio record/playback engine. NUM_CLIPS clips share one
// single-port BRAM. Each clip owns a fixed CLIP_DEPTH-sample region, so the
// BRAM address is simply {clip, offset}. The engine keeps the recorded length
// of every clip and plays a clip either once or in a loop.
//
// Ports
//   clock        scaled system clock, everything on posedge
//   reset        synchronous, active-high
//   clip_sel     clip number, sampled only on an accepted record/play pulse
//   record       1-cycle start-record pulse (wins over play)
//   play         1-cycle start-play pulse
//   stop         1-cycle abort pulse
//   loop_mode    1 = wrap playback to start of clip, sampled at play start
//   in_valid     deserializer sample-done pulse
//   in_data      captured sample, valid with in_valid
//   out_ready    serializer accepts out_data this cycle
//   out_valid    out_data holds a sample
//   out_data     playback sample
//   mem_en       BRAM enable
//   mem_wen      BRAM write enable
//   mem_addr     BRAM address {clip, offset}
//   mem_wdata    BRAM write data
//   mem_rdata    BRAM read data, one cycle after mem_en
//   state        0 IDLE, 1 RECORD, 2 PLAY
//   active_clip  clip latched at the last accepted start
//   done         1-cycle pulse: record reached full, or one-shot play ended
//
// Playback handshake: a sample transfers on every cycle where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data is held stable
// until that transfer happens (or stop aborts playback); out_valid does not
// depend combinationally on out_ready.
// ----------------------------------------------------------------------------
module clip_record_play_ctrl #(
  parameter int NUM_CLIPS  = 4,
  parameter int CLIP_DEPTH = 16384,
  parameter int SAMPLE_W   = 16,
  parameter int CLIP_W     = $clog2(NUM_CLIPS),
  parameter int OFF_W      = $clog2(CLIP_DEPTH),
  parameter int ADDR_W     = CLIP_W + OFF_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CLIP_W-1:0]   clip_sel,
  input  logic                record,
  input  logic                play,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                mem_en,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic [1:0]          state,
  output logic [CLIP_W-1:0]   active_clip,
  output logic                done
);

  localparam int LEN_W = OFF_W + 1;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CLIP_DEPTH - 1);

  // PLAY_REQ is the cycle mem_en is high, PLAY_WAIT the BRAM latency cycle,
  // PLAY_OUT holds the sample until the serializer takes it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY_REQ,
    S_PLAY_WAIT,
    S_PLAY_OUT
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [1:0]          state_q, state_d;
  logic [CLIP_W-1:0]   clip_q, clip_d;
  logic                loop_q, loop_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [LEN_W-1:0]    len_q [NUM_CLIPS];
  logic [LEN_W-1:0]    len_d [NUM_CLIPS];
  logic                mem_en_q, mem_en_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SAMPLE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic                out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                done_q, done_d;

  // Offset arithmetic stays OFF_W bits wide so it never carries into the clip field.
  logic [OFF_W-1:0]    off_inc;
  logic [LEN_W-1:0]    off_inc_len;
  assign off_inc     = off_q + OFF_W'(1);
  assign off_inc_len = {1'b0, off_q} + LEN_W'(1);

  always_comb begin
    fsm_d       = fsm_q;
    clip_d      = clip_q;
    loop_d      = loop_q;
    off_d       = off_q;
    len_d       = len_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (record) begin
          clip_d          = clip_sel;
          len_d[clip_sel] = '0;
          off_d           = '0;
          fsm_d           = S_RECORD;
        end else if (play && (len_q[clip_sel] != '0)) begin
          clip_d     = clip_sel;
          loop_d     = loop_mode;
          off_d      = '0;
          fsm_d      = S_PLAY_REQ;
          mem_en_d   = 1'b1;
          mem_addr_d = {clip_sel, {OFF_W{1'b0}}};
        end
      end

      S_RECORD: begin
        // stop has priority: a sample arriving with stop is dropped.
        if (stop) begin
          fsm_d = S_IDLE;
        end else if (in_valid) begin
          mem_en_d      = 1'b1;
          mem_wen_d     = 1'b1;
          mem_addr_d    = {clip_q, off_q};
          mem_wdata_d   = in_data;
          off_d         = off_inc;
          len_d[clip_q] = off_inc_len;
          if (off_q == OFF_LAST) begin
            done_d = 1'b1;
            fsm_d  = S_IDLE;
          end
        end
      end

      S_PLAY_REQ: begin
        fsm_d = stop ? S_IDLE : S_PLAY_WAIT;
      end

      S_PLAY_WAIT: begin
        if (stop) begin
          fsm_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = mem_rdata;
          fsm_d       = S_PLAY_OUT;
        end
      end

      S_PLAY_OUT: begin
        if (stop) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (off_inc_len < len_q[clip_q]) begin
            off_d      = off_inc;
            fsm_d      = S_PLAY_REQ;
            mem_en_d   = 1'b1;
            mem_addr_d = {clip_q, off_inc};
          end else if (loop_q) begin
            off_d      = '0;
            fsm_d      = S_PLAY_REQ;
            mem_en_d   = 1'b1;
            mem_addr_d = {clip_q, {OFF_W{1'b0}}};
          end else begin
            done_d = 1'b1;
            fsm_d  = S_IDLE;
          end
        end
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    case (fsm_d)
      S_RECORD:                           state_d = 2'd1;
      S_PLAY_REQ, S_PLAY_WAIT, S_PLAY_OUT: state_d = 2'd2;
      default:                            state_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      state_q     <= 2'd0;
      clip_q      <= '0;
      loop_q      <= 1'b0;
      off_q       <= '0;
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      clip_q      <= clip_d;
      loop_q      <= loop_d;
      off_q       <= off_d;
      len_q       <= len_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign state       = state_q;
  assign active_clip = clip_q;
  assign mem_en      = mem_en_q;
  assign mem_wen     = mem_wen_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign done        = done_q;

endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clip_record_play_ctrl
//
// Directed bench for clip_record_play_ctrl with NUM_CLIPS=4, CLIP_DEPTH=8,
// SAMPLE_W=16. A behavioural single-port BRAM with one-cycle read latency
// sits on the memory port. A cycle-by-cycle vector table covers record,
// stop-in-record, one-shot play and start arbitration; hand-written
// sequences cover the full-clip record, looping play with stop under
// backpressure, and reset during play.
// ----------------------------------------------------------------------------
module tb_clip_record_play_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  clip_sel;
  logic        record, play, stop, loop_mode;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        mem_en, mem_wen;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  state;
  logic [1:0]  active_clip;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  clip_record_play_ctrl #(
    .NUM_CLIPS(4), .CLIP_DEPTH(8), .SAMPLE_W(16)
  ) dut (
    .clock(clk), .reset(rst), .clip_sel(clip_sel), .record(record),
    .play(play), .stop(stop), .loop_mode(loop_mode), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state), .active_clip(active_clip), .done(done)
  );

  // Behavioural BRAM: 32 words, one-cycle read latency.
  logic [15:0] bram [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) bram[mem_addr] <= mem_wdata;
      else         mem_rdata <= bram[mem_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    record = 0; play = 0; stop = 0; in_valid = 0; in_data = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rec, ply, stp; logic [1:0] sel; logic lp, iv; logic [15:0] idata; logic ordy;
    logic [1:0] e_state; logic [1:0] e_clip; logic e_en, e_wen; logic [4:0] e_addr;
    logic [15:0] e_wdata; logic e_ov; logic [15:0] e_od; logic e_done;
  } vec_t;

  function automatic vec_t mk(
    input logic rec, ply, stp, input logic [1:0] sel, input logic lp, iv,
    input logic [15:0] idata, input logic ordy,
    input logic [1:0] e_state, input logic [1:0] e_clip, input logic e_en, e_wen,
    input logic [4:0] e_addr, input logic [15:0] e_wdata, input logic e_ov,
    input logic [15:0] e_od, input logic e_done);
    vec_t v;
    v.rec = rec; v.ply = ply; v.stp = stp; v.sel = sel; v.lp = lp; v.iv = iv;
    v.idata = idata; v.ordy = ordy; v.e_state = e_state; v.e_clip = e_clip;
    v.e_en = e_en; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_ov = e_ov; v.e_od = e_od; v.e_done = e_done;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    //              rec ply stp sel lp iv data    rdy | st clip en wen addr   wdata   ov od      done
    // record clip 2, three samples, then stop together with a dropped sample
    vecs[0]  = mk(1, 0, 0, 2, 0, 0, 16'h0,  1,  1, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 16'h11, 1,  1, 2, 1, 1, 5'h10, 16'h11, 0, 16'h0,  0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 16'h22, 1,  1, 2, 1, 1, 5'h11, 16'h22, 0, 16'h0,  0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 16'h33, 1,  1, 2, 1, 1, 5'h12, 16'h33, 0, 16'h0,  0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 16'h44, 1,  0, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    // one-shot play clip 2, out_ready high: REQ, WAIT, OUT per sample
    vecs[5]  = mk(0, 1, 0, 2, 0, 0, 16'h0,  1,  2, 2, 1, 0, 5'h10, 16'h0,  0, 16'h0,  0);
    vecs[6]  = mk(0, 0, 0, 2, 0, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[7]  = mk(0, 0, 0, 2, 0, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  1, 16'h11, 0);
    vecs[8]  = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 1, 0, 5'h11, 16'h0,  0, 16'h0,  0);
    vecs[9]  = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[10] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  1, 16'h22, 0);
    vecs[11] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 1, 0, 5'h12, 16'h0,  0, 16'h0,  0);
    vecs[12] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[13] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  2, 2, 0, 0, 5'h00, 16'h0,  1, 16'h33, 0);
    vecs[14] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  0, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  1);
    vecs[15] = mk(0, 0, 0, 3, 1, 0, 16'h0,  1,  0, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    // play on empty clip 3 ignored; record+play together enters RECORD
    vecs[16] = mk(0, 1, 0, 3, 0, 0, 16'h0,  1,  0, 2, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[17] = mk(1, 1, 0, 3, 0, 0, 16'h0,  1,  1, 3, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
    vecs[18] = mk(0, 0, 1, 3, 0, 0, 16'h0,  1,  0, 3, 0, 0, 5'h00, 16'h0,  0, 16'h0,  0);
  end

  // ---------------- test sequence ----------------
  initial begin
    int  done_cnt;
    bit  got;
    logic [15:0] e;

    rst = 1; idle_inputs(); clip_sel = 0; loop_mode = 0; out_ready = 0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_active_clip", active_clip, 0);
    chk("rst_done", done, 0);
    rst = 0;
    step();

    // table-driven portion
    for (int i = 0; i < 19; i++) begin
      record = vecs[i].rec; play = vecs[i].ply; stop = vecs[i].stp;
      clip_sel = vecs[i].sel; loop_mode = vecs[i].lp; in_valid = vecs[i].iv;
      in_data = vecs[i].idata; out_ready = vecs[i].ordy;
      step();
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_clip", i), active_clip, vecs[i].e_clip);
      chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].e_en);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, vecs[i].e_wen);
      if (vecs[i].e_en) chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_wen) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
    end
    idle_inputs();

    // record clip 1 with 9 samples: 8 writes, done after the 8th, 9th ignored
    record = 1; clip_sel = 1; step(); record = 0;
    chk("rec1_state", state, 1);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_data = 16'h100 + 16'(i);
      step();
      if (i < 8) begin
        chk($sformatf("rec1_en_%0d", i), mem_en, 1);
        chk($sformatf("rec1_wen_%0d", i), mem_wen, 1);
        chk($sformatf("rec1_addr_%0d", i), mem_addr, 5'h08 + 5'(i));
        chk($sformatf("rec1_wdata_%0d", i), mem_wdata, 16'h100 + 16'(i));
        chk($sformatf("rec1_done_%0d", i), done, (i == 7) ? 1 : 0);
        chk($sformatf("rec1_state_%0d", i), state, (i == 7) ? 0 : 1);
      end else begin
        chk("rec1_ninth_en", mem_en, 0);
        chk("rec1_ninth_done", done, 0);
        chk("rec1_ninth_state", state, 0);
      end
    end
    idle_inputs();

    // one-shot play of clip 1 proves len[1]=8
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h100 + 16'(i));
    out_ready = 1; loop_mode = 0; play = 1; clip_sel = 1; step(); play = 0;
    chk("play1_state", state, 2);
    done_cnt = 0;
    for (int c = 0; c < 100 && done_cnt == 0; c++) begin
      if (out_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
        chk("play1_data", out_data, e);
      end
      if (done) done_cnt++;
      else step();
    end
    chk("play1_done_seen", done_cnt, 1);
    chk("play1_all_out", exp_q.size(), 0);
    step();
    chk("play1_done_single", done, 0);
    chk("play1_idle", state, 0);
    exp_q.delete();

    // looping play of clip 2, then stop under backpressure
    exp_q.push_back(16'h11); exp_q.push_back(16'h22); exp_q.push_back(16'h33);
    exp_q.push_back(16'h11); exp_q.push_back(16'h22);
    out_ready = 1; loop_mode = 1; play = 1; clip_sel = 2; step(); play = 0;
    done_cnt = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (done) done_cnt++;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("loop_data", out_data, e);
        if (exp_q.size() == 0) begin
          out_ready = 0;
          got = 1;
        end
      end
      step();
    end
    chk("loop_reached_fifth", got, 1);
    chk("loop_no_done", done_cnt, 0);
    step();
    chk("loop_hold_valid", out_valid, 1);
    chk("loop_hold_data", out_data, 16'h22);
    stop = 1; step(); stop = 0;
    chk("loop_stop_valid", out_valid, 0);
    chk("loop_stop_state", state, 0);
    chk("loop_stop_en", mem_en, 0);
    chk("loop_stop_done", done, 0);
    exp_q.delete();

    // reset during play clears lengths
    out_ready = 1; loop_mode = 0; play = 1; clip_sel = 2; step(); play = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rstplay_state", state, 0);
    chk("rstplay_en", mem_en, 0);
    chk("rstplay_valid", out_valid, 0);
    chk("rstplay_data", out_data, 0);
    chk("rstplay_addr", mem_addr, 0);
    chk("rstplay_clip", active_clip, 0);
    chk("rstplay_done", done, 0);
    play = 1; clip_sel = 2; step(); play = 0;
    chk("rstplay_ignored_state", state, 0);
    chk("rstplay_ignored_en", mem_en, 0);
    step();
    chk("rstplay_ignored_en2", mem_en, 0);
    chk("rstplay_ignored_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
